// File: rtl/frame_capture_ctrl.sv
// Camera frame-window capture controller: waits for a frame boundary, then writes the
// in-window pixels to a frame buffer in raster order. Define CAPTURE_CONTINUOUS_EN to re-arm from DONE.
module frame_capture_ctrl #(
  parameter int X_START = 48,
  parameter int Y_START = 8,
  parameter int WIN_W   = 224,
  parameter int WIN_H   = 224,
  parameter int ADDR_W  = 16
) (
  input  logic              i_pclk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_vsync,
  input  logic              i_pixelValid,
  input  logic [15:0]       i_pixel,
  input  logic [9:0]        i_xIndex,
  input  logic [9:0]        i_yIndex,
  output logic              o_wrEn,
  output logic [ADDR_W-1:0] o_wrAddr,
  output logic [15:0]       o_wrData,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam int TOTAL = WIN_W * WIN_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL);

  typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             start_block_q;
  logic             clr, wr, err_set, block_set;
  logic [10:0]      col, row;
  logic             in_win;

  // i_xIndex is 1-based; index 0 wraps to 2047 and is rejected explicitly anyway
  assign col    = {1'b0, i_xIndex} - 11'd1;
  assign row    = {1'b0, i_yIndex};
  assign in_win = (i_xIndex != 10'd0)
               && (col >= 11'(X_START)) && (col < 11'(X_START + WIN_W))
               && (row >= 11'(Y_START)) && (row < 11'(Y_START + WIN_H));

  assign o_busy = (state_q == ARM) || (state_q == SYNC) || (state_q == CAPTURE);
  assign o_done = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    wr        = 1'b0;
    err_set   = 1'b0;
    block_set = 1'b0;
    case (state_q)
      IDLE:
        if (i_start && !start_block_q) begin
          state_d = ARM;
          clr     = 1'b1;
        end
      ARM:  if (i_vsync)  state_d = SYNC;
      SYNC: if (!i_vsync) state_d = CAPTURE;
      CAPTURE:
        // counter reaches TOTAL on the edge that issues the last write; leave on the next edge
        if (cnt_q == LAST_CNT) state_d = DONE;
        else if (i_vsync) begin
          state_d = DONE;
          err_set = 1'b1;
        end else if (i_pixelValid && in_win) wr = 1'b1;
      DONE: begin
`ifdef CAPTURE_CONTINUOUS_EN
        if (i_start) begin
          state_d = ARM;
          clr     = 1'b1;
        end else state_d = IDLE;
`else
        // a start level still held from this capture must drop before re-arming
        state_d   = IDLE;
        block_set = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      o_wrEn        <= 1'b0;
      o_wrAddr      <= '0;
      o_wrData      <= '0;
      o_error       <= 1'b0;
      start_block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      o_wrEn  <= wr;
      if (wr) begin
        o_wrAddr <= ADDR_W'(cnt_q);
        o_wrData <= i_pixel;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      if (clr) begin
        cnt_q   <= '0;
        o_error <= 1'b0;
      end
      if (err_set) o_error <= 1'b1;
      if (block_set)     start_block_q <= 1'b1;
      else if (!i_start) start_block_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Randomized bench for frame_capture_ctrl: expected writes come from the window geometry
// (in-window pixels in raster order, truncated at a short frame), compared against a monitor log.
module tb_frame_capture_ctrl;
  localparam int XS = 2, YS = 1, W = 4, H = 3, N = W * H, AW = 16;

  logic          clk = 1'b0;
  logic          rst, st, vs, pv;
  logic [15:0]   px;
  logic [9:0]    xi, yi;
  logic          wr_en, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  int          errors = 0, checks = 0;
  logic [31:0] act_q[$], exp_q[$];
  int          done_cnt = 0, cyc = 0, done_cyc = 0, last_wr_cyc = 0;
  bit          exp_err;
  int          mark, dbase;

  always #5 clk = ~clk;

  frame_capture_ctrl #(.X_START(XS), .Y_START(YS), .WIN_W(W), .WIN_H(H), .ADDR_W(AW)) dut (
    .i_pclk(clk), .i_reset(rst), .i_start(st), .i_vsync(vs), .i_pixelValid(pv),
    .i_pixel(px), .i_xIndex(xi), .i_yIndex(yi),
    .o_wrEn(wr_en), .o_wrAddr(wr_addr), .o_wrData(wr_data),
    .o_busy(busy), .o_done(done), .o_error(err)
  );

  // write/done monitor, sampled away from the rising edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      act_q.push_back({16'(wr_addr), wr_data});
      last_wr_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_pulse();
    st = 1'b1; tick(); st = 1'b0;
  endtask

  task automatic strobe(input int x, input int y, input logic [15:0] p);
    pv = 1'b1; xi = 10'(x + 1); yi = 10'(y); px = p;
    tick(); pv = 1'b0; tick();
  endtask

  // One camera frame: vsync blank, then rows of strobes with random gaps. cut>=0 reasserts
  // vsync at the start of that row. capt says whether the reference expects this frame captured.
  task automatic frame(input int cols, input int rows, input int cut, input bit mid_start, input bit capt);
    int k;
    logic [15:0] pix;
    k = 0;
    vs = 1'b1; repeat (3) tick();
    vs = 1'b0; repeat (2) tick();
    for (int y = 0; y < rows && y != cut; y++) begin
      for (int x = 0; x < cols; x++) begin
        pix = 16'($urandom);
        pv = 1'b1; xi = 10'(x + 1); yi = 10'(y); px = pix;
        if (mid_start && y == 2 && x == 0) st = 1'b1;
        if (capt && x >= XS && x < XS + W && y >= YS && y < YS + H) begin
          if (k < N) exp_q.push_back({16'(k), pix});
          k++;
        end
        tick();
        pv = 1'b0;
        if (mid_start) st = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      repeat (2) tick();
    end
    vs = 1'b1; repeat (4) tick();
    exp_err = capt && (k < N);
  endtask

  task automatic verify(input string tag, input int m, input int db, input int nd);
    tick();
    for (int i = 0; i < 50 && (done_cnt - db) < nd; i++) tick();
    chk({tag, "_nwr"}, 32'(act_q.size() - m), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (m + i < act_q.size()) chk({tag, "_wr"}, act_q[m + i], exp_q[i]);
    chk({tag, "_done"}, 32'(done_cnt - db), 32'(nd));
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; st = 1'b0; vs = 1'b1; pv = 1'b0; px = '0; xi = '0; yi = '0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_wren", {31'd0, wr_en}, 0);
    chk("rst_err",  {31'd0, err}, 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", 32'(wr_data), 0);
    rst = 1'b0; tick();

    // single-strobe latency, then outputs hold with wrEn low
    start_pulse();
    vs = 1'b1; repeat (2) tick();
    vs = 1'b0; repeat (2) tick();
    pv = 1'b1; xi = 10'd3; yi = 10'd1; px = 16'hABCD;
    tick(); pv = 1'b0;
    chk("lat_en",   {31'd0, wr_en}, 1);
    chk("lat_addr", 32'(wr_addr), 0);
    chk("lat_data", 32'(wr_data), 32'h0000ABCD);
    xi = 10'd4; tick();
    chk("hold_en",   {31'd0, wr_en}, 0);
    chk("hold_addr", 32'(wr_addr), 0);
    chk("hold_data", 32'(wr_data), 32'h0000ABCD);
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // full frame
    mark = act_q.size(); dbase = done_cnt;
    start_pulse();
    frame(6, 5, -1, 1'b0, 1'b1);
    verify("full", mark, dbase, 1);
    chk("done_lat", 32'(done_cyc - last_wr_cyc), 1);
    chk("full_idle", {31'd0, busy}, 0);

    // short frame: vsync back after row 2
    mark = act_q.size(); dbase = done_cnt;
    start_pulse();
    frame(6, 5, 3, 1'b0, 1'b1);
    verify("short", mark, dbase, 1);
    start_pulse();
    chk("err_clr", {31'd0, err}, 0);
    chk("rearm_busy", {31'd0, busy}, 1);
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // arm mid-frame with vsync low: nothing written until a frame boundary
    vs = 1'b0;
    mark = act_q.size(); dbase = done_cnt;
    start_pulse();
    chk("arm_busy", {31'd0, busy}, 1);
    for (int y = YS; y < YS + H; y++)
      for (int x = XS; x < XS + W; x++) strobe(x, y, 16'($urandom));
    tick();
    chk("arm_nowr", 32'(act_q.size() - mark), 0);
    frame(6, 5, -1, 1'b1, 1'b1);
    verify("arm", mark, dbase, 1);

    // reset after five writes
    mark = act_q.size();
    start_pulse();
    vs = 1'b1; repeat (2) tick();
    vs = 1'b0; repeat (2) tick();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 6; x++)
        if (!(y == 2 && x > 2)) strobe(x, y, 16'($urandom));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_wren", {31'd0, wr_en}, 0);
    chk("mrst_done", {31'd0, done}, 0);
    chk("mrst_addr", 32'(wr_addr), 0);
    tick();
    chk("mrst_nwr", 32'(act_q.size() - mark), 5);
    mark = act_q.size(); dbase = done_cnt;
    start_pulse();
    frame(6, 5, -1, 1'b0, 1'b1);
    verify("post_rst", mark, dbase, 1);

    // randomized geometry and truncation
    for (int it = 0; it < 5; it++) begin
      int cols, rows, cut;
      cols = $urandom_range(6, 8);
      rows = $urandom_range(4, 6);
      cut  = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 4);
      mark = act_q.size(); dbase = done_cnt;
      start_pulse();
      frame(cols, rows, cut, 1'b0, 1'b1);
      verify("rand", mark, dbase, 1);
    end

    // start held high across two frames
    mark = act_q.size(); dbase = done_cnt;
    st = 1'b1;
    frame(6, 5, -1, 1'b0, 1'b1);
`ifdef CAPTURE_CONTINUOUS_EN
    frame(6, 5, -1, 1'b0, 1'b1);
    st = 1'b0;
    verify("cont", mark, dbase, 2);
    chk("cont_rearm", {31'd0, busy}, 1);
`else
    frame(6, 5, -1, 1'b0, 1'b0);
    st = 1'b0;
    verify("cont", mark, dbase, 1);
    chk("cont_idle", {31'd0, busy}, 0);
`endif
    rst = 1'b1; tick(); rst = 1'b0; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 Parameters SHALL be X_START, 48, first captured column; Y_START, 8, first captured row; WIN_W, 224, window width in pixels; WIN_H, 224, window height in rows; ADDR_W, 16, write-address width.
REQ-002 i_pclk  input  1  sole clock; all logic on rising edge.
REQ-003 i_reset  input  1  reset, synchronous, active-high.
REQ-004 i_start  input  1  capture request, level-sampled.
REQ-005 i_vsync  input  1  camera vertical sync, high between frames.
REQ-006 i_pixelValid  input  1  one-cycle strobe, pixel complete.
REQ-007 i_pixel  input  16  RGB565 pixel, valid with i_pixelValid.
REQ-008 i_xIndex  input  10  1-based column count at strobe (column = i_xIndex-1).
REQ-009 i_yIndex  input  10  0-based row index.
REQ-010 o_wrEn  output  1  frame-buffer write strobe.
REQ-011 o_wrAddr  output  ADDR_W  frame-buffer write address.
REQ-012 o_wrData  output  16  frame-buffer write data.
REQ-013 o_busy  output  1  capture in progress.
REQ-014 o_done  output  1  one-cycle end-of-capture pulse.
REQ-015 o_error  output  1  last capture truncated; sticky until next accepted i_start.

Function
REQ-016 FSM states SHALL be IDLE, ARM, SYNC, CAPTURE, DONE.
REQ-017 IDLE->ARM when i_start=1: clear o_error, pixel counter and address counter.
REQ-018 ARM->SYNC when i_vsync=1; SYNC->CAPTURE when i_vsync=0. Capture always begins on a frame boundary.
REQ-019 o_busy SHALL be 1 in ARM, SYNC and CAPTURE, and 0 in IDLE and DONE.
REQ-020 In CAPTURE, a strobe is in-window iff X_START <= i_xIndex-1 < X_START+WIN_W and Y_START <= i_yIndex < Y_START+WIN_H.
REQ-021 For an in-window strobe, the next cycle SHALL have o_wrEn=1, o_wrData=i_pixel and o_wrAddr=address counter. The counter then increments. Latency is exactly 1 cycle.
REQ-022 Out-of-window strobes, and any strobe outside CAPTURE, SHALL produce no write.
REQ-023 Addresses SHALL run 0..WIN_W*WIN_H-1 in raster order, with no gaps.
REQ-024 When the write of pixel WIN_W*WIN_H-1 is issued, the FSM goes CAPTURE->DONE.
REQ-025 If i_vsync=1 in CAPTURE before the final write: o_error=1, go to DONE, no further writes.
REQ-026 DONE SHALL last exactly one cycle with o_done=1, then go to IDLE (see REQ-031).
REQ-027 i_start SHALL be ignored in every state except IDLE (and DONE when CAPTURE_CONTINUOUS_EN is defined).
REQ-028 o_wrEn SHALL be 0 whenever no write is issued. o_wrAddr and o_wrData hold their last values.

Reset
REQ-029 i_reset=1 at any clock edge, including mid-capture, SHALL force IDLE. It SHALL clear all outputs, counters and o_error to 0 on that edge, with no o_done pulse.

Configuration
REQ-030 Macro CAPTURE_CONTINUOUS_EN selects continuous capture.
REQ-031 Macro defined: DONE->ARM if i_start=1 in DONE (clearing counters and o_error), else DONE->IDLE. Macro undefined: DONE->IDLE unconditionally.

Verification (bench parameters: X_START=2, Y_START=1, WIN_W=4, WIN_H=3)
REQ-032 Full frame: i_start pulse, vsync high then low, 6 cols x 5 rows of strobes -> 12 writes, addrs 0..11. First write follows the strobe at row 1, col 2. o_done is one cycle after write 11; o_error=0.
REQ-033 Data/latency: strobe with i_pixel=16'hABCD at row 1, col 2 -> next cycle o_wrEn=1, o_wrAddr=0, o_wrData=16'hABCD.
REQ-034 Short frame: vsync reasserted after row 2 (8 writes) -> o_error=1, o_done pulse, no write at addr 8. o_error clears on the next i_start.
REQ-035 Arm alignment: i_start asserted mid-frame with strobes, vsync low -> no writes until vsync 1->0 is seen. i_start during CAPTURE does not restart the capture.
REQ-036 Reset mid-capture after 5 writes -> next cycle o_busy=0, o_wrEn=0, o_done=0, state IDLE. A new capture starts at addr 0.
REQ-037 Macro defined, i_start held high across two frames -> two o_done pulses, each capture addrs 0..11. Macro undefined -> single o_done, then idle.
